// File: rtl/arbitro_memoria_dados_pkg.sv
// Shared widths, port identifiers and the command record for the data-memory arbiter.
// Define ARB_ROUND_ROBIN_EN to build the round-robin pick instead of fixed priority.
package pkg_memoria_dados;

    localparam int LARGURA_DADO = 8;
    localparam int LARGURA_END  = 8;

    localparam logic PORTA_CPU = 1'b0;
    localparam logic PORTA_ES  = 1'b1;

    // One accepted access waiting in the CMD stage; "ender" is the address field.
    typedef struct packed {
        logic                    valido;
        logic                    porta;
        logic                    wr;
        logic [LARGURA_END-1:0]  ender;
        logic [LARGURA_DADO-1:0] dado;
    } cmd_t;

endpackage

// File: rtl/arbitro_memoria_dados_rr.sv
// Combinational 2-way pick. With ARB_ROUND_ROBIN_EN the port that was not granted last
// wins a conflict; otherwise port 0 always wins.
module arbitro_rr_2 (
    input  logic [1:0] req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic       ultimo_i,
`endif
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
        if (req_i == 2'b11) begin
            gnt_o = ultimo_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
`else
        if (req_i[0]) begin
            gnt_o = 2'b01;
        end else if (req_i[1]) begin
            gnt_o = 2'b10;
        end
`endif
    end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Two-port arbiter and ARB/CMD/RSP sequencer for the single-port data memory.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration (fixed priority to port 0 otherwise).
module arbitro_memoria_dados #(
    parameter int LARGURA_DADO = 8,
    parameter int LARGURA_END  = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Req0,
    input  logic                    Req1,
    input  logic                    Wr0,
    input  logic                    Wr1,
    input  logic [LARGURA_END-1:0]  End0,
    input  logic [LARGURA_END-1:0]  End1,
    input  logic [LARGURA_DADO-1:0] Dado0,
    input  logic [LARGURA_DADO-1:0] Dado1,
    output logic                    Gnt0,
    output logic                    Gnt1,
    output logic                    Valido0,
    output logic                    Valido1,
    output logic [LARGURA_DADO-1:0] DadoLido,
    output logic [LARGURA_END-1:0]  Endereco,
    output logic [LARGURA_DADO-1:0] DadoEscr,
    output logic                    MenWrite,
    output logic                    MenRead,
    input  logic [LARGURA_DADO-1:0] DadoLidoMem
);
    import pkg_memoria_dados::*;

    // Handshake: a requester holds Req with stable fields until its Gnt; the access is
    // accepted in the cycle Gnt is high and Req may carry a new access the cycle after.
    logic [1:0]              req;
    logic [1:0]              gnt;
    cmd_t                    cmd_q, cmd_d;
    logic [1:0]              valido_q, valido_d;
    logic [LARGURA_DADO-1:0] lido_q, lido_d;

    assign req = {Req1, Req0} & {2{~Reset}};

`ifdef ARB_ROUND_ROBIN_EN
    logic ultimo_q, ultimo_d;

    always_comb begin
        ultimo_d = ultimo_q;
        if (gnt[1]) begin
            ultimo_d = PORTA_ES;
        end else if (gnt[0]) begin
            ultimo_d = PORTA_CPU;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ultimo_q <= PORTA_ES;
        end else begin
            ultimo_q <= ultimo_d;
        end
    end

    arbitro_rr_2 u_arb (.req_i(req), .ultimo_i(ultimo_q), .gnt_o(gnt));
`else
    arbitro_rr_2 u_arb (.req_i(req), .gnt_o(gnt));
`endif

    assign Gnt0 = gnt[0];
    assign Gnt1 = gnt[1];

    // Address/data keep their last value when idle; only the valid bit clears.
    always_comb begin
        cmd_d        = cmd_q;
        cmd_d.valido = 1'b0;
        if (gnt[1]) begin
            cmd_d.valido = 1'b1;
            cmd_d.porta  = PORTA_ES;
            cmd_d.wr     = Wr1;
            cmd_d.ender  = End1;
            cmd_d.dado   = Dado1;
        end else if (gnt[0]) begin
            cmd_d.valido = 1'b1;
            cmd_d.porta  = PORTA_CPU;
            cmd_d.wr     = Wr0;
            cmd_d.ender  = End0;
            cmd_d.dado   = Dado0;
        end
    end

    always_comb begin
        valido_d = 2'b00;
        lido_d   = lido_q;
        if (cmd_q.valido && !cmd_q.wr) begin
            valido_d[cmd_q.porta] = 1'b1;
            lido_d                = DadoLidoMem;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cmd_q    <= '0;
            valido_q <= 2'b00;
            lido_q   <= '0;
        end else begin
            cmd_q    <= cmd_d;
            valido_q <= valido_d;
            lido_q   <= lido_d;
        end
    end

    assign Endereco = cmd_q.ender;
    assign DadoEscr = cmd_q.dado;
    assign MenWrite = cmd_q.valido & cmd_q.wr;
    assign MenRead  = cmd_q.valido & ~cmd_q.wr;
    assign Valido0  = valido_q[0];
    assign Valido1  = valido_q[1];
    assign DadoLido = lido_q;

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Bench for arbitro_memoria_dados: behavioural memory, grant-order reference model and
// scenario tasks; follows ARB_ROUND_ROBIN_EN like the design.
module tb_arbitro_memoria_dados;

    logic       Clock, Reset;
    logic       Req0, Req1, Wr0, Wr1;
    logic [7:0] End0, End1, Dado0, Dado1;
    logic       Gnt0, Gnt1, Valido0, Valido1;
    logic [7:0] DadoLido, Endereco, DadoEscr, DadoLidoMem;
    logic       MenWrite, MenRead;

    arbitro_memoria_dados #(.LARGURA_DADO(8), .LARGURA_END(8)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
        .End0(End0), .End1(End1), .Dado0(Dado0), .Dado1(Dado1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Valido0(Valido0), .Valido1(Valido1),
        .DadoLido(DadoLido), .Endereco(Endereco), .DadoEscr(DadoEscr),
        .MenWrite(MenWrite), .MenRead(MenRead), .DadoLidoMem(DadoLidoMem)
    );

    // clock / memory
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [7:0] mem [256];
    always @(posedge Clock) if (MenWrite) mem[Endereco] <= DadoEscr;
    assign DadoLidoMem = MenRead ? mem[Endereco] : 8'h00;

    // reference model and scoreboard
    logic [7:0]  ref_mem [256];
    logic [24:0] exp_q[$];        // {grant cycle[15:0], port, data}
    logic        ult_m;
    logic [1:0]  g_seen;
    int          cyc, n_acc, n_val;
    int          n_tests, n_fail;

    task automatic tick();
        logic [1:0]  eg;
        logic [24:0] e;
        logic        p;
        @(negedge Clock);
        g_seen = {Gnt1, Gnt0};
        if (Reset) begin
            exp_q.delete();
            ult_m = 1'b1;
        end else begin
            cyc++;
            if (Req0 && Req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                eg = ult_m ? 2'b01 : 2'b10;
`else
                eg = 2'b01;
`endif
            end else begin
                eg = {Req1, Req0};
            end
            n_tests++;
            if (g_seen !== eg) begin
                n_fail++;
                $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, g_seen, eg);
            end
            n_tests++;
            if ((MenWrite & MenRead) !== 1'b0) begin
                n_fail++;
                $display("FAIL mem_excl cyc=%0d wr=%b rd=%b exp not both", cyc, MenWrite, MenRead);
            end
            if (MenWrite || MenRead) n_acc++;
            if (Valido0 || Valido1) begin
                n_val++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_extra cyc=%0d valido=%b%b exp none", cyc, Valido1, Valido0);
                end else begin
                    e = exp_q.pop_front();
                    if ({Valido1, Valido0, DadoLido, cyc[15:0]} !==
                        {e[8], ~e[8], e[7:0], e[24:9] + 16'd2}) begin
                        n_fail++;
                        $display("FAIL rsp cyc=%0d got valido=%b%b dado=%h exp port=%0d dado=%h at cyc=%0d",
                                 cyc, Valido1, Valido0, DadoLido, e[8], e[7:0], e[24:9] + 16'd2);
                    end
                end
            end else if (exp_q.size() > 0 && cyc[15:0] > exp_q[0][24:9] + 16'd2) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_missing cyc=%0d got none exp port=%0d dado=%h",
                         cyc, exp_q[0][8], exp_q[0][7:0]);
                void'(exp_q.pop_front());
            end
            if (eg != 2'b00) begin
                p = eg[1];
                if (p ? Wr1 : Wr0) ref_mem[p ? End1 : End0] = p ? Dado1 : Dado0;
                else exp_q.push_back({cyc[15:0], p, ref_mem[p ? End1 : End0]});
                ult_m = p;
            end
        end
        @(posedge Clock);
        #1;
    endtask

    // driver: hold one request until granted
    task automatic acesso(input logic p, input logic wr, input logic [7:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        if (p) begin Req1 = 1'b1; Wr1 = wr; End1 = a; Dado1 = d; end
        else   begin Req0 = 1'b1; Wr0 = wr; End0 = a; Dado0 = d; end
        for (int k = 0; k < 16 && !got; k++) begin
            tick();
            got = p ? g_seen[1] : g_seen[0];
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL gnt_timeout port=%0d got no grant exp grant within 16 cycles", p);
        end
        if (p) Req1 = 1'b0; else Req0 = 1'b0;
    endtask

    task automatic test_reset();
        logic [29:0] outs;
        Req0 = 1'b1; Wr0 = 1'b0; End0 = 8'h05;
        repeat (2) @(posedge Clock);
        #1;
        outs = {Gnt1, Gnt0, MenWrite, MenRead, Valido1, Valido0, Endereco, DadoEscr, DadoLido};
        n_tests++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outs got=%h exp=0", outs); end
        Req0 = 1'b0;
        Reset = 1'b0;
        tick();
        acesso(1'b0, 1'b0, 8'h05, 8'h00);
        n_tests++;
        if (MenRead !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rd got=%b exp=1", MenRead); end
        Reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            outs = {Gnt1, Gnt0, MenWrite, MenRead, Valido1, Valido0, Endereco, DadoEscr, DadoLido};
            n_tests++;
            if (outs !== '0) begin n_fail++; $display("FAIL midreset_outs k=%0d got=%h exp=0", k, outs); end
            if (k < 2) tick();
        end
        Reset = 1'b0;
        tick();
        n_tests++;
        if ({Valido1, Valido0} !== 2'b00) begin
            n_fail++;
            $display("FAIL flushed_valido got=%b%b exp=00", Valido1, Valido0);
        end
        Req0 = 1'b1; Wr0 = 1'b1; End0 = 8'h10; Dado0 = 8'h55;
        Req1 = 1'b1; Wr1 = 1'b1; End1 = 8'h10; Dado1 = 8'h66;
        tick();
        n_tests++;
        if (g_seen !== 2'b01) begin n_fail++; $display("FAIL first_conflict got=%b exp=01", g_seen); end
        Req0 = 1'b0;
        Req1 = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        acesso(1'b0, 1'b1, 8'h3C, 8'hA5);
        n_tests++;
        if ({MenWrite, MenRead, Endereco, DadoEscr} !== {2'b10, 8'h3C, 8'hA5}) begin
            n_fail++;
            $display("FAIL wr_cmd got w=%b r=%b a=%h d=%h exp w=1 r=0 a=3c d=a5",
                     MenWrite, MenRead, Endereco, DadoEscr);
        end
        acesso(1'b0, 1'b0, 8'h3C, 8'h00);
        tick();
        n_tests++;
        if ({Valido0, Valido1, DadoLido} !== {2'b10, 8'hA5}) begin
            n_fail++;
            $display("FAIL rd_after_wr got v0=%b v1=%b d=%h exp v0=1 v1=0 d=a5", Valido0, Valido1, DadoLido);
        end
    endtask

    task automatic test_hazard();
        acesso(1'b1, 1'b1, 8'hFF, 8'h7E);
        acesso(1'b0, 1'b0, 8'hFF, 8'h00);
        tick();
        n_tests++;
        if ({Valido0, DadoLido} !== {1'b1, 8'h7E}) begin
            n_fail++;
            $display("FAIL hazard got v0=%b d=%h exp v0=1 d=7e", Valido0, DadoLido);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] eg;
        acesso(1'b0, 1'b1, 8'h01, 8'h11);
        acesso(1'b1, 1'b1, 8'h02, 8'h22);
        Req0 = 1'b1; Wr0 = 1'b0; End0 = 8'h01;
        Req1 = 1'b1; Wr1 = 1'b0; End1 = 8'h02;
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef ARB_ROUND_ROBIN_EN
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            eg = 2'b01;
`endif
            n_tests++;
            if (g_seen !== eg) begin
                n_fail++;
                $display("FAIL rr_seq i=%0d got=%b exp=%b", i, g_seen, eg);
            end
        end
        Req0 = 1'b0;
        Req1 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_sweep();
        int c0, a0, v0;
        c0 = cyc;
        a0 = n_acc;
        v0 = n_val;
        for (int i = 0; i < 256; i++) acesso(1'b1, 1'b1, 8'(i), 8'(i));
        for (int i = 0; i < 256; i++) acesso(1'b1, 1'b0, 8'(i), 8'h00);
        n_tests++;
        if (cyc - c0 !== 512) begin
            n_fail++;
            $display("FAIL sweep_cycles got=%0d exp=512", cyc - c0);
        end
        repeat (3) tick();
        n_tests++;
        if ({n_acc - a0, n_val - v0} !== {32'd512, 32'd256}) begin
            n_fail++;
            $display("FAIL sweep_counts got acc=%0d val=%0d exp acc=512 val=256", n_acc - a0, n_val - v0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!Req0 && $urandom_range(0, 3) != 0) begin
                Req0 = 1'b1; Wr0 = 1'($urandom_range(0, 1));
                End0 = 8'($urandom_range(0, 15)); Dado0 = 8'($urandom_range(0, 255));
            end else if (Req0 && $urandom_range(0, 9) == 0) begin
                Req0 = 1'b0;
            end
            if (!Req1 && $urandom_range(0, 3) != 0) begin
                Req1 = 1'b1; Wr1 = 1'($urandom_range(0, 1));
                End1 = 8'($urandom_range(0, 15)); Dado1 = 8'($urandom_range(0, 255));
            end else if (Req1 && $urandom_range(0, 9) == 0) begin
                Req1 = 1'b0;
            end
            tick();
            if (g_seen[0]) Req0 = 1'b0;
            if (g_seen[1]) Req1 = 1'b0;
        end
        Req0 = 1'b0;
        Req1 = 1'b0;
        repeat (4) tick();
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL random_drain got=%0d pending exp=0", exp_q.size());
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; n_acc = 0; n_val = 0;
        ult_m = 1'b1; g_seen = 2'b00;
        Reset = 1'b1;
        Req0 = 1'b0; Req1 = 1'b0; Wr0 = 1'b0; Wr1 = 1'b0;
        End0 = 8'h00; End1 = 8'h00; Dado0 = 8'h00; Dado1 = 8'h00;
        test_reset();
        test_write_read();
        test_hazard();
        test_round_robin();
        test_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
